// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: PC register, unconditional-branch next-PC, IFID pipeline register.
// Latency: word at InstrAddr in cycle N shows on IFID_* in cycle N+1; null word halts fetch.
// Backpressure: IFID_Valid && !IFID_Ready freezes PC, IFID_* and FetchCount; Redirect overrides.
module instruction_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        CLK,
    input  logic        Reset,
    output logic [63:0] InstrAddr,
    input  logic [31:0] InstrData,
    input  logic        Redirect,
    input  logic [63:0] RedirectPC,
    input  logic        IFID_Ready,
    output logic        IFID_Valid,
    output logic [31:0] IFID_Instr,
    output logic [63:0] IFID_PC,
    output logic        Halted,
    output logic [31:0] FetchCount
);

    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

    localparam logic [5:0] OPC_B = 6'b000101;

    state_t      state;
    logic [63:0] pc;
    logic [63:0] branch_off;
    logic [63:0] next_pc;
    logic        stall;

    assign InstrAddr = pc;
    assign stall     = IFID_Valid && !IFID_Ready;

    // B immediate is a signed word offset; additions wrap naturally at 64 bits.
    assign branch_off = {{36{InstrData[25]}}, InstrData[25:0], 2'b00};
    assign next_pc    = (InstrData[31:26] == OPC_B) ? (pc + branch_off) : (pc + 64'd4);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            pc         <= RESET_PC;
            state      <= RUN;
            Halted     <= 1'b0;
            IFID_Valid <= 1'b0;
            IFID_Instr <= 32'h0;
            IFID_PC    <= 64'h0;
            FetchCount <= 32'h0;
        end else if (Redirect) begin
            pc         <= RedirectPC;
            state      <= RUN;
            Halted     <= 1'b0;
            IFID_Valid <= 1'b0;
        end else if (!stall) begin
            // Not stalled means the IFID slot is empty or draining this edge.
            if (state == RUN && InstrData != 32'h0) begin
                pc         <= next_pc;
                IFID_Valid <= 1'b1;
                IFID_Instr <= InstrData;
                IFID_PC    <= pc;
                if (FetchCount != 32'hFFFF_FFFF)
                    FetchCount <= FetchCount + 32'd1;
            end else begin
                state      <= HALT;
                Halted     <= 1'b1;
                IFID_Valid <= 1'b0;
            end
        end
    end

endmodule
